// File: rtl/mon_commit_gen.sv
// Monitor commit packet producer: registers one sanitised, numbered packet per retired
// instruction and raises sticky protocol errors (PC discontinuity, commit after halt, watchdog).
module mon_commit_gen #(
   parameter logic [31:0] RESET_PC  = 32'h1eceb000,
   parameter logic [31:0] HALT_INST = 32'h0000006f,
   parameter int          TIMEOUT   = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [31:0] wb_inst,
   input  logic [31:0] wb_pc,
   input  logic [31:0] wb_pc_next,
   input  logic [4:0]  wb_rs1_addr,
   input  logic [4:0]  wb_rs2_addr,
   input  logic [31:0] wb_rs1_rdata,
   input  logic [31:0] wb_rs2_rdata,
   input  logic [4:0]  wb_rd_addr,
   input  logic [31:0] wb_rd_wdata,
   input  logic [31:0] wb_mem_addr,
   input  logic [3:0]  wb_mem_rmask,
   input  logic [3:0]  wb_mem_wmask,
   input  logic [31:0] wb_mem_rdata,
   input  logic [31:0] wb_mem_wdata,
   output logic        mon_valid,
   output logic [63:0] mon_order,
   output logic        mon_halt,
   output logic [31:0] mon_inst,
   output logic [31:0] mon_pc,
   output logic [31:0] mon_pc_next,
   output logic [4:0]  mon_rs1_addr,
   output logic [4:0]  mon_rs2_addr,
   output logic [31:0] mon_rs1_rdata,
   output logic [31:0] mon_rs2_rdata,
   output logic [4:0]  mon_rd_addr,
   output logic [31:0] mon_rd_wdata,
   output logic [31:0] mon_mem_addr,
   output logic [3:0]  mon_mem_rmask,
   output logic [3:0]  mon_mem_wmask,
   output logic [31:0] mon_mem_rdata,
   output logic [31:0] mon_mem_wdata,
   output logic        err_pc_discont,
   output logic        err_after_halt,
   output logic        err_timeout,
   output logic        error
);

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] m);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++)
         if (m[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
      return (v == WD_MAX) ? v : v + WD_W'(1);
   endfunction

   logic [63:0]     order_cnt;
   logic [31:0]     exp_pc;
   logic            halted;
   logic [WD_W-1:0] wdog;
   logic            is_halt;
   logic            pc_bad;
   logic [WD_W-1:0] wdog_inc;

   assign is_halt  = wb_valid && (wb_inst == HALT_INST);
   assign pc_bad   = wb_valid && (wb_pc != exp_pc);
   assign wdog_inc = sat_inc(wdog);
   assign error    = err_pc_discont | err_after_halt | err_timeout;

   // Output register stage: packet, sequence number and sticky error flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mon_valid      <= 1'b0;
         mon_order      <= '0;
         mon_halt       <= 1'b0;
         mon_inst       <= '0;
         mon_pc         <= '0;
         mon_pc_next    <= '0;
         mon_rs1_addr   <= '0;
         mon_rs2_addr   <= '0;
         mon_rs1_rdata  <= '0;
         mon_rs2_rdata  <= '0;
         mon_rd_addr    <= '0;
         mon_rd_wdata   <= '0;
         mon_mem_addr   <= '0;
         mon_mem_rmask  <= '0;
         mon_mem_wmask  <= '0;
         mon_mem_rdata  <= '0;
         mon_mem_wdata  <= '0;
         err_pc_discont <= 1'b0;
         err_after_halt <= 1'b0;
         err_timeout    <= 1'b0;
         order_cnt      <= '0;
         exp_pc         <= RESET_PC;
         halted         <= 1'b0;
         wdog           <= '0;
      end else begin
         mon_valid <= wb_valid;
         mon_halt  <= is_halt;
         if (wb_valid) begin
            mon_order     <= order_cnt;
            mon_inst      <= wb_inst;
            mon_pc        <= wb_pc;
            mon_pc_next   <= wb_pc_next;
            mon_rs1_addr  <= wb_rs1_addr;
            mon_rs2_addr  <= wb_rs2_addr;
            mon_rs1_rdata <= wb_rs1_rdata;
            mon_rs2_rdata <= wb_rs2_rdata;
            mon_rd_addr   <= wb_rd_addr;
            mon_rd_wdata  <= (wb_rd_addr == 5'd0) ? 32'd0 : wb_rd_wdata;
            mon_mem_addr  <= wb_mem_addr;
            mon_mem_rmask <= wb_mem_rmask;
            mon_mem_wmask <= wb_mem_wmask;
            mon_mem_rdata <= mask_bytes(wb_mem_rdata, wb_mem_rmask);
            mon_mem_wdata <= mask_bytes(wb_mem_wdata, wb_mem_wmask);
            order_cnt     <= order_cnt + 64'd1;
            exp_pc        <= wb_pc_next;
            wdog          <= '0;
            if (is_halt) halted         <= 1'b1;
            if (pc_bad)  err_pc_discont <= 1'b1;
            if (halted)  err_after_halt <= 1'b1;
         end else if (!halted) begin
            // A commit on the expiry cycle takes the branch above, so it never flags
            wdog <= wdog_inc;
            if (TIMEOUT != 0 && wdog_inc == WD_MAX) err_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mon_commit_gen.sv
// Scoreboard bench for mon_commit_gen: directed commits push expected packets,
// a negedge monitor pops and compares whenever mon_valid is high.
module tb_mon_commit_gen;

   localparam logic [31:0] RPC  = 32'h1eceb000;
   localparam logic [31:0] HALT = 32'h0000006f;
   localparam logic [31:0] NOP  = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_valid = 1'b0;
   logic [31:0] wb_inst = '0, wb_pc = '0, wb_pc_next = '0;
   logic [4:0]  wb_rs1_addr = '0, wb_rs2_addr = '0, wb_rd_addr = '0;
   logic [31:0] wb_rs1_rdata = '0, wb_rs2_rdata = '0, wb_rd_wdata = '0, wb_mem_addr = '0;
   logic [3:0]  wb_mem_rmask = '0, wb_mem_wmask = '0;
   logic [31:0] wb_mem_rdata = '0, wb_mem_wdata = '0;

   logic        mon_valid, mon_halt;
   logic [63:0] mon_order;
   logic [31:0] mon_inst, mon_pc, mon_pc_next, mon_rs1_rdata, mon_rs2_rdata;
   logic [4:0]  mon_rs1_addr, mon_rs2_addr, mon_rd_addr;
   logic [31:0] mon_rd_wdata, mon_mem_addr, mon_mem_rdata, mon_mem_wdata;
   logic [3:0]  mon_mem_rmask, mon_mem_wmask;
   logic        err_pc_discont, err_after_halt, err_timeout, error;

   mon_commit_gen #(.RESET_PC(RPC), .HALT_INST(HALT), .TIMEOUT(10)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_pc(wb_pc),
      .wb_pc_next(wb_pc_next), .wb_rs1_addr(wb_rs1_addr), .wb_rs2_addr(wb_rs2_addr),
      .wb_rs1_rdata(wb_rs1_rdata), .wb_rs2_rdata(wb_rs2_rdata), .wb_rd_addr(wb_rd_addr),
      .wb_rd_wdata(wb_rd_wdata), .wb_mem_addr(wb_mem_addr), .wb_mem_rmask(wb_mem_rmask),
      .wb_mem_wmask(wb_mem_wmask), .wb_mem_rdata(wb_mem_rdata), .wb_mem_wdata(wb_mem_wdata),
      .mon_valid(mon_valid), .mon_order(mon_order), .mon_halt(mon_halt), .mon_inst(mon_inst),
      .mon_pc(mon_pc), .mon_pc_next(mon_pc_next), .mon_rs1_addr(mon_rs1_addr),
      .mon_rs2_addr(mon_rs2_addr), .mon_rs1_rdata(mon_rs1_rdata), .mon_rs2_rdata(mon_rs2_rdata),
      .mon_rd_addr(mon_rd_addr), .mon_rd_wdata(mon_rd_wdata), .mon_mem_addr(mon_mem_addr),
      .mon_mem_rmask(mon_mem_rmask), .mon_mem_wmask(mon_mem_wmask),
      .mon_mem_rdata(mon_mem_rdata), .mon_mem_wdata(mon_mem_wdata),
      .err_pc_discont(err_pc_discont), .err_after_halt(err_after_halt),
      .err_timeout(err_timeout), .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   typedef struct {
      int           due;
      logic [63:0]  order;
      logic         halt;
      logic [31:0]  rd_wdata;
      logic [31:0]  mem_rdata;
      logic [31:0]  mem_wdata;
      logic [2:0]   err;
      logic [214:0] pass;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   logic [214:0] mon_pass;
   assign mon_pass = {mon_inst, mon_pc, mon_pc_next, mon_rs1_rdata, mon_rs2_rdata, mon_mem_addr,
                      mon_rs1_addr, mon_rs2_addr, mon_rd_addr, mon_mem_rmask, mon_mem_wmask};

   // Monitor: every presented packet must match the oldest expectation
   always @(negedge clk) begin
      if (rst && mon_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pkt: got order %0h required no packet", mon_order);
         end else begin
            mon_e = sb.pop_front();
            chk("latency",   cyc, mon_e.due);
            chk("order",     mon_order, mon_e.order);
            chk("halt",      mon_halt, mon_e.halt);
            chk("rd_wdata",  mon_rd_wdata, mon_e.rd_wdata);
            chk("mem_rdata", mon_mem_rdata, mon_e.mem_rdata);
            chk("mem_wdata", mon_mem_wdata, mon_e.mem_wdata);
            chk("err_flags", {err_pc_discont, err_after_halt, err_timeout}, mon_e.err);
            chk("error",     error, |mon_e.err);
            chk("passthru",  mon_pass, mon_e.pass);
         end
      end
   end

   task automatic commit(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] pcn,
                         input logic [4:0] rd, input logic [31:0] rdw,
                         input logic [3:0] rm, input logic [31:0] rdat,
                         input logic [3:0] wm, input logic [31:0] wdat,
                         input logic [31:0] e_rd, input logic [31:0] e_mr, input logic [31:0] e_mw,
                         input logic [63:0] e_ord, input logic e_halt, input logic [2:0] e_err);
      exp_t e;
      wb_valid     = 1'b1;
      wb_inst      = inst;
      wb_pc        = pc;
      wb_pc_next   = pcn;
      wb_rs1_addr  = pc[6:2];
      wb_rs2_addr  = pc[11:7];
      wb_rs1_rdata = pc ^ 32'h5a5a0000;
      wb_rs2_rdata = ~pc;
      wb_rd_addr   = rd;
      wb_rd_wdata  = rdw;
      wb_mem_addr  = {pc[31:2], 2'b00} + 32'h400;
      wb_mem_rmask = rm;
      wb_mem_rdata = rdat;
      wb_mem_wmask = wm;
      wb_mem_wdata = wdat;
      e.due       = cyc + 1;
      e.order     = e_ord;
      e.halt      = e_halt;
      e.rd_wdata  = e_rd;
      e.mem_rdata = e_mr;
      e.mem_wdata = e_mw;
      e.err       = e_err;
      e.pass      = {inst, pc, pcn, wb_rs1_rdata, wb_rs2_rdata, wb_mem_addr,
                     wb_rs1_addr, wb_rs2_addr, rd, rm, wm};
      sb.push_back(e);
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      wb_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, {mon_valid, mon_halt, err_pc_discont, err_after_halt, err_timeout, error}, 0);
      chk({tag, "_order"}, mon_order, 0);
      chk({tag, "_pass"}, mon_pass, 0);
      chk({tag, "_data"}, {mon_rd_wdata, mon_mem_rdata, mon_mem_wdata}, 0);
   endtask

   task automatic apply_reset();
      chk("sb_drained", sb.size(), 0);
      sb.delete();
      wb_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_zero("rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #2;
      // 1: sequential commits, then the register-zero / byte-mask sanitising
      apply_reset();
      commit(NOP, RPC,        RPC + 32'h4, 5'd1, 32'h11, 4'h0, 32'hffffffff, 4'h0, 32'hffffffff,
             32'h11, 32'h0, 32'h0, 64'd0, 1'b0, 3'b000);
      commit(NOP, RPC + 32'h4, RPC + 32'h8, 5'd2, 32'h22, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h22, 32'h0, 32'h0, 64'd1, 1'b0, 3'b000);
      commit(NOP, RPC + 32'h8, RPC + 32'hc, 5'd3, 32'h33, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h33, 32'h0, 32'h0, 64'd2, 1'b0, 3'b000);
      idle(1);
      chk("idle_valid_low", mon_valid, 0);
      commit(NOP, RPC + 32'hc, RPC + 32'h10, 5'd0, 32'hdeadbeef, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 64'd3, 1'b0, 3'b000);
      commit(NOP, RPC + 32'h10, RPC + 32'h14, 5'd5, 32'h55, 4'b0011, 32'h12345678, 4'h0, 32'haabbccdd,
             32'h55, 32'h00005678, 32'h0, 64'd4, 1'b0, 3'b000);
      commit(NOP, RPC + 32'h14, RPC + 32'h18, 5'd0, 32'h1, 4'h0, 32'h12345678, 4'b1100, 32'haabbccdd,
             32'h0, 32'h0, 32'haabb0000, 64'd5, 1'b0, 3'b000);
      idle(1);
      // 3: PC discontinuity is flagged on the second packet and stays set
      apply_reset();
      commit(NOP, RPC, 32'h1eceb100, 5'd1, 32'h1, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h1, 32'h0, 32'h0, 64'd0, 1'b0, 3'b000);
      commit(NOP, RPC + 32'h4, RPC + 32'h8, 5'd1, 32'h2, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h2, 32'h0, 32'h0, 64'd1, 1'b0, 3'b100);
      commit(NOP, RPC + 32'h8, RPC + 32'hc, 5'd1, 32'h3, 4'hf, 32'hcafef00d, 4'h0, 32'h0,
             32'h3, 32'hcafef00d, 32'h0, 64'd2, 1'b0, 3'b100);
      idle(1);
      // 4: halt, then a commit after halt
      apply_reset();
      commit(HALT, RPC, RPC + 32'h4, 5'd0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 64'd0, 1'b1, 3'b000);
      commit(NOP, RPC + 32'h4, RPC + 32'h8, 5'd1, 32'h9, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h9, 32'h0, 32'h0, 64'd1, 1'b0, 3'b010);
      idle(1);
      // halt commit at a wrong PC raises both halt and the discontinuity flag
      apply_reset();
      commit(HALT, RPC + 32'h20, RPC + 32'h24, 5'd0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 64'd0, 1'b1, 3'b100);
      idle(1);
      // 5: watchdog expires after 10 idle cycles
      apply_reset();
      idle(9);
      chk("timeout_at_9", err_timeout, 0);
      idle(1);
      chk("timeout_at_10", err_timeout, 1);
      chk("timeout_error", error, 1);
      // a commit on the expiry cycle clears it; halting freezes the watchdog
      apply_reset();
      idle(9);
      commit(HALT, RPC, RPC + 32'h4, 5'd0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h0, 32'h0, 32'h0, 64'd0, 1'b1, 3'b000);
      idle(15);
      chk("timeout_frozen", err_timeout, 0);
      // 6: asynchronous reset mid-stream after order 5
      apply_reset();
      for (int i = 0; i < 6; i++)
         commit(NOP, RPC + 32'(4 * i), RPC + 32'(4 * i + 4), 5'd7, 32'(i + 100), 4'h0, 32'h0, 4'h0,
                32'h0, 32'(i + 100), 32'h0, 32'h0, 64'(i), 1'b0, 3'b000);
      #2;
      chk("pre_rst_valid", mon_valid, 1);
      chk("pre_rst_order", mon_order, 5);
      rst = 1'b0;
      #1;
      check_zero("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      commit(NOP, RPC, RPC + 32'h4, 5'd1, 32'h77, 4'h0, 32'h0, 4'h0, 32'h0,
             32'h77, 32'h0, 32'h0, 64'd0, 1'b0, 3'b000);
      idle(2);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
